// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler: one leaky-integrate-and-fire datapath shared across N_NEURONS, one neuron per FETCH/UPD pair
`timescale 1ns/1ps
module lif_step_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2,
    localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1,
    localparam int RW = REFRACT > 0 ? $clog2(REFRACT + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 tick,
    input  logic [WIDTH-1:0]     thresh,
    input  logic [WIDTH-1:0]     cur_in,
    output logic [IW-1:0]        cur_idx,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes,
    output logic [WIDTH-1:0]     mem_out
);
    typedef enum logic [1:0] {IDLE, FETCH, UPD, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] v [N_NEURONS];
    logic [RW-1:0] r [N_NEURONS];
    logic [IW-1:0] idx;
    logic [WIDTH-1:0] thr, v_rd, s_sat, v_new;
    logic [RW-1:0] r_rd, r_new;
    logic [WIDTH:0] sum;
    logic [N_NEURONS-1:0] shadow;
    logic last, fire;
    assign cur_idx = idx;
    assign last = idx == IW'(N_NEURONS - 1);
    // state register; ena low freezes the walk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (ena) state <= state_nx;
    end
    // next state: IDLE waits for tick, then FETCH/UPD per neuron, DONE publishes
    always_comb begin
        state_nx = state == IDLE  ? (tick ? FETCH : IDLE) :
                   state == FETCH ? UPD :
                   state == UPD   ? (last ? DONE : FETCH) : IDLE;
    end
    // outputs decoded from state alone
    always_comb begin
        busy = state != IDLE;
        done = state == DONE;
    end
    // leak, integrate with saturation, threshold and refractory decision
    always_comb begin
        sum   = {1'b0, v_rd} - {1'b0, v_rd >> LEAK_SHIFT} + {1'b0, cur_in};
        s_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        fire  = r_rd == '0 && s_sat >= thr;
        v_new = (r_rd != '0 || fire) ? '0 : s_sat;
        r_new = r_rd != '0 ? r_rd - RW'(1) : fire ? RW'(REFRACT) : '0;
    end
    // register files, neuron walk index and published results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            thr     <= '0;
            v_rd    <= '0;
            r_rd    <= '0;
            shadow  <= '0;
            spikes  <= '0;
            mem_out <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i] <= '0;
                r[i] <= '0;
            end
        end else if (ena) begin
            case (state)
                IDLE: if (tick) begin
                    thr    <= thresh;
                    idx    <= '0;
                    shadow <= '0;
                end
                FETCH: begin
                    v_rd <= v[idx];
                    r_rd <= r[idx];
                end
                UPD: begin
                    v[idx]      <= v_new;
                    r[idx]      <= r_new;
                    mem_out     <= v_new;
                    shadow[idx] <= fire;
                    if (!last) idx <= idx + IW'(1);
                end
                default: spikes <= shadow;
            endcase
        end
    end
endmodule

// File: tb/tb_lif_step_scheduler.sv
// tb_lif_step_scheduler: directed steps with a scoreboard of per-step spike vectors and final membrane value
`timescale 1ns/1ps
module tb_lif_step_scheduler;
    localparam int N = 4;
    typedef struct packed {logic [3:0] sp; logic [7:0] mem;} exp_t;
    logic clk = 0, rst_n = 0, ena = 1, tick = 0;
    logic [7:0] thresh = 0, cur_in, mem_out;
    logic [1:0] cur_idx;
    logic busy, done, pend = 0;
    logic [3:0] spikes;
    logic [7:0] cur_tab [N] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] mv [N];
    int mr [N];
    int checks = 0, errors = 0, edges;
    logic [1:0] seen [N];
    exp_t q[$];
    exp_t mon_e;
    logic [7:0] mv0;

    lif_step_scheduler #(.N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRACT(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .thresh(thresh), .cur_in(cur_in),
        .cur_idx(cur_idx), .busy(busy), .done(done), .spikes(spikes), .mem_out(mem_out)
    );

    always #5 clk = ~clk;
    // indexed side bus: current table addressed by the DUT
    always_comb cur_in = cur_tab[cur_idx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = 0;
            mr[n] = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        int s;
        e = '0;
        for (int n = 0; n < N; n++) begin
            if (mr[n] > 0) begin
                mv[n] = 0;
                mr[n]--;
            end else begin
                s = int'(mv[n]) - int'(mv[n] >> 1) + int'(cur_tab[n]);
                if (s > 255) s = 255;
                if (s >= int'(thresh)) begin
                    e.sp[n] = 1'b1;
                    mv[n] = 0;
                    mr[n] = 2;
                end else begin
                    mv[n] = 8'(s);
                    mr[n] = 0;
                end
            end
        end
        e.mem = mv[N-1];
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            cyc();
            k++;
        end
        chk({tag, "_drain"}, 32'(q.size()), 0);
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 0;
        model_reset();
        q.delete();
        cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic step(input string tag);
        model_step();
        tick = 1;
        cyc();
        tick = 0;
        drain(tag);
    endtask

    // monitor: done must match a pending expectation; spikes are checked the cycle after done
    always @(negedge clk) begin
        if (done) begin
            chk("done_has_expectation", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("mem_out_at_done", 32'(mem_out), 32'(q[0].mem));
            pend <= 1'b1;
        end else if (pend) begin
            pend <= 1'b0;
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("spikes", 32'(spikes), 32'(mon_e.sp));
            end
        end
    end

    initial begin
        // reset with tick held high
        thresh = 200;
        tick = 1;
        model_reset();
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spikes", spikes, 0);
        chk("rst_mem_out", mem_out, 0);
        chk("rst_cur_idx", cur_idx, 0);
        model_step();
        rst_n = 1;
        cyc();
        chk("leave_idle", busy, 1);
        tick = 0;
        drain("t1");
        // integrate, fire, refractory, recover
        do_reset();
        thresh = 200;
        cur_tab[0] = 150;
        step("t2_s1");
        step("t2_s2");
        chk("t2_spk_step2", spikes, 4'b0001);
        step("t2_s3");
        step("t2_s4");
        chk("t2_spk_step4", spikes, 4'b0000);
        step("t2_s5");
        // saturation to 255 still fires at threshold 255
        do_reset();
        thresh = 255;
        cur_tab = '{8'd0, 8'd200, 8'd0, 8'd0};
        step("t3_s1");
        chk("t3_spk_step1", spikes, 4'b0000);
        step("t3_s2");
        chk("t3_spk_step2", spikes, 4'b0010);
        // latency, ignored ticks while busy, cur_idx walk, latched threshold
        do_reset();
        thresh = 100;
        cur_tab = '{8'd10, 8'd20, 8'd30, 8'd40};
        model_step();
        tick = 1;
        cyc();
        tick = 0;
        thresh = 0;
        edges = 0;
        while (!done && edges < 30) begin
            if (edges % 2 == 0 && edges < 8) seen[edges / 2] = cur_idx;
            tick = edges >= 2 && edges <= 5;
            cyc();
            edges++;
        end
        tick = 0;
        chk("t4_latency_edges", edges, 8);
        for (int i = 0; i < N; i++) chk($sformatf("t4_cur_idx%0d", i), seen[i], i);
        chk("t4_idx_hold_done", cur_idx, 3);
        cyc();
        chk("t4_done_one_cycle", done, 0);
        drain("t4");
        repeat (12) cyc();
        chk("t4_no_second_step", busy, 0);
        thresh = 100;
        // enable freeze mid-step delays done by exactly the frozen cycles
        model_step();
        mv0 = mv[0];
        tick = 1;
        cyc();
        tick = 0;
        cyc();
        cyc();
        edges = 2;
        ena = 0;
        repeat (5) begin
            cyc();
            edges++;
        end
        chk("t5_frz_mem_out", mem_out, mv0);
        chk("t5_frz_cur_idx", cur_idx, 1);
        chk("t5_frz_busy", busy, 1);
        chk("t5_frz_done", done, 0);
        ena = 1;
        while (!done && edges < 40) begin
            cyc();
            edges++;
        end
        chk("t5_latency_edges", edges, 13);
        drain("t5a");
        // reset mid-step aborts with no done and clears membranes
        tick = 1;
        cyc();
        tick = 0;
        repeat (3) cyc();
        rst_n = 0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_mem", mem_out, 0);
        model_reset();
        cyc();
        rst_n = 1;
        repeat (12) cyc();
        chk("t5_no_resume", busy, 0);
        step("t5b");
        chk("t5_fresh_v3", mem_out, 40);
        // zero threshold: everyone fires, then refractory
        do_reset();
        thresh = 0;
        cur_tab = '{8'd0, 8'd0, 8'd0, 8'd0};
        step("t6_s1");
        chk("t6_spk1", spikes, 4'b1111);
        step("t6_s2");
        chk("t6_spk2", spikes, 4'b0000);
        step("t6_s3");
        chk("t6_spk3", spikes, 4'b0000);
        step("t6_s4");
        chk("t6_spk4", spikes, 4'b1111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
